// File: rtl/gmii_pkg.sv
// Shared types and constants for the GMII transmit framer and related CRC logic.
package gmii_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_ABORT,
    ST_DRAIN,
    ST_IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

  localparam int PRE_BYTES = 7;
  localparam int FCS_BYTES = 4;

  // Select one byte of the inverted CRC; FCS goes out least significant byte first.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] fcs;
    logic [7:0]  b;
    fcs = ~crc;
    case (idx)
      2'd0:    b = fcs[7:0];
      2'd1:    b = fcs[15:8];
      2'd2:    b = fcs[23:16];
      default: b = fcs[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/gmii_tx_framer_if.sv
// Byte stream carrying one Ethernet frame per packet (destination MAC to last payload byte).
interface gmii_tx_framer_if;

  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/crc32_d8.sv
// Combinational byte-wide step of the reflected Ethernet CRC-32 (LSB of data first).
// No init or final inversion here so the receive checker can reuse it unchanged.
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Fold the byte into the low bits, then shift the LFSR eight times.
  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: adds preamble/SFD, pads to minimum length, appends FCS,
// enforces inter-frame gap and aborts frames on underrun or oversize.
//
// The state register runs one cycle ahead of the pins: whatever a state decides
// is registered into txd/txen/txer and shows up on the following cycle. That is
// why the IDLE->PRE transition already emits the first preamble byte, and why
// the ABORT state coincides with the single TXER cycle on the pins.
module gmii_tx_framer
  import gmii_pkg::*;
#(
  parameter int IFG_BYTES = 12,
  parameter int MIN_DATA  = 60,
  parameter int MAX_DATA  = 1514
) (
  input  logic              clk,
  input  logic              rst,
  gmii_tx_framer_if.slave   s,
  output logic [7:0]        txd,
  output logic              txen,
  output logic              txer,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       abort_cnt
);

  // The first preamble byte comes from the IDLE transition, so PRE covers the rest.
  localparam logic [7:0]  PRE_LAST = 8'(PRE_BYTES - 2);
  localparam logic [7:0]  FCS_LAST = 8'(FCS_BYTES - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [10:0] MIN_CNT  = 11'(MIN_DATA);
  localparam logic [10:0] MAX_CNT  = 11'(MAX_DATA);

  state_t      state, state_nxt;
  logic [31:0] crc, crc_nxt, crc_step;
  logic [7:0]  crc_data;
  logic [10:0] byte_cnt, byte_cnt_nxt;
  logic [7:0]  cyc_cnt, cyc_cnt_nxt;
  logic [7:0]  txd_nxt;
  logic        txen_nxt;
  logic        txer_nxt;
  logic [15:0] frame_cnt_nxt, abort_cnt_nxt;
  logic        ready_int;

  // Ready depends on state alone so the upstream valid never loops back into it.
  assign ready_int = (state == ST_DATA) || (state == ST_DRAIN);
  assign s.ready   = ready_int;
  assign busy      = (state != ST_IDLE);

  // Pad bytes are zero; only DATA feeds stream bytes into the CRC.
  assign crc_data = (state == ST_DATA) ? s.data : 8'h00;

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (crc_data),
    .crc_out (crc_step)
  );

  // State, counters, CRC and the registered GMII pins; reset truncates any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      crc       <= CRC_INIT;
      byte_cnt  <= 11'd0;
      cyc_cnt   <= 8'd0;
      txd       <= 8'h00;
      txen      <= 1'b0;
      txer      <= 1'b0;
      frame_cnt <= 16'd0;
      abort_cnt <= 16'd0;
    end else begin
      state     <= state_nxt;
      crc       <= crc_nxt;
      byte_cnt  <= byte_cnt_nxt;
      cyc_cnt   <= cyc_cnt_nxt;
      txd       <= txd_nxt;
      txen      <= txen_nxt;
      txer      <= txer_nxt;
      frame_cnt <= frame_cnt_nxt;
      abort_cnt <= abort_cnt_nxt;
    end
  end

  // Next-state and next-pin decisions for every framer state.
  always_comb begin
    state_nxt     = state;
    crc_nxt       = crc;
    byte_cnt_nxt  = byte_cnt;
    cyc_cnt_nxt   = cyc_cnt;
    txd_nxt       = 8'h00;
    txen_nxt      = 1'b0;
    txer_nxt      = 1'b0;
    frame_cnt_nxt = frame_cnt;
    abort_cnt_nxt = abort_cnt;

    case (state)
      ST_IDLE: begin
        if (s.valid) begin
          state_nxt   = ST_PRE;
          cyc_cnt_nxt = 8'd0;
          txd_nxt     = PREAMBLE_BYTE;
          txen_nxt    = 1'b1;
        end
      end

      ST_PRE: begin
        txd_nxt  = PREAMBLE_BYTE;
        txen_nxt = 1'b1;
        if (cyc_cnt == PRE_LAST) begin
          state_nxt = ST_SFD;
        end else begin
          cyc_cnt_nxt = cyc_cnt + 8'd1;
        end
      end

      ST_SFD: begin
        txd_nxt      = SFD_BYTE;
        txen_nxt     = 1'b1;
        crc_nxt      = CRC_INIT;
        byte_cnt_nxt = 11'd0;
        state_nxt    = ST_DATA;
      end

      ST_DATA: begin
        txen_nxt = 1'b1;
        if (!s.valid) begin
          txer_nxt  = 1'b1;
          state_nxt = ST_ABORT;
        end else if ((byte_cnt == MAX_CNT) && !s.last) begin
          // The offending byte is consumed but replaced by the error marker.
          txer_nxt  = 1'b1;
          state_nxt = ST_ABORT;
        end else begin
          txd_nxt      = s.data;
          crc_nxt      = crc_step;
          byte_cnt_nxt = byte_cnt + 11'd1;
          if (s.last) begin
            cyc_cnt_nxt = 8'd0;
            state_nxt   = ((byte_cnt + 11'd1) < MIN_CNT) ? ST_PAD : ST_FCS;
          end
        end
      end

      ST_PAD: begin
        txen_nxt     = 1'b1;
        crc_nxt      = crc_step;
        byte_cnt_nxt = byte_cnt + 11'd1;
        if ((byte_cnt + 11'd1) >= MIN_CNT) begin
          cyc_cnt_nxt = 8'd0;
          state_nxt   = ST_FCS;
        end
      end

      ST_FCS: begin
        txen_nxt = 1'b1;
        txd_nxt  = fcs_byte(crc, cyc_cnt[1:0]);
        if (cyc_cnt == FCS_LAST) begin
          frame_cnt_nxt = frame_cnt + 16'd1;
          cyc_cnt_nxt   = 8'd0;
          state_nxt     = ST_IFG;
        end else begin
          cyc_cnt_nxt = cyc_cnt + 8'd1;
        end
      end

      ST_ABORT: begin
        state_nxt = ST_DRAIN;
      end

      ST_DRAIN: begin
        if (s.valid && s.last) begin
          abort_cnt_nxt = abort_cnt + 16'd1;
          cyc_cnt_nxt   = 8'd0;
          state_nxt     = ST_IFG;
        end
      end

      ST_IFG: begin
        if (cyc_cnt == IFG_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          cyc_cnt_nxt = cyc_cnt + 8'd1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: normal, padded, back-to-back, underrun,
// oversize and mid-frame reset scenarios.
module tb_gmii_tx_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  txd;
  logic        txen;
  logic        txer;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] abort_cnt;

  gmii_tx_framer_if s_if();

  gmii_tx_framer dut (
    .clk       (clk),
    .rst       (rst),
    .s         (s_if),
    .txd       (txd),
    .txen      (txen),
    .txer      (txer),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .abort_cnt (abort_cnt)
  );

  always #4 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  int         rise_q[$];
  int         fall_q[$];
  int         txen_cycles = 0;
  int         txer_cycles = 0;
  int         mon_cyc     = 0;
  logic       prev_txen   = 1'b0;

  // Capture every byte on the wire while TXEN is high and note TXEN edges.
  always @(negedge clk) begin
    mon_cyc <= mon_cyc + 1;
    if (txen === 1'b1) begin
      cap_q.push_back(txd);
      txen_cycles <= txen_cycles + 1;
    end
    if (txer === 1'b1) txer_cycles <= txer_cycles + 1;
    if ((txen === 1'b1) && !prev_txen) rise_q.push_back(mon_cyc);
    if ((txen === 1'b0) && prev_txen) fall_q.push_back(mon_cyc);
    prev_txen <= (txen === 1'b1);
  end

  function automatic logic [7:0] pat(input int idx);
    logic [31:0] v;
    v = idx * 7 + 3;
    return v[7:0];
  endfunction

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Expected wire image of a good frame of len stream bytes.
  task automatic build_expected(input int len);
    logic [31:0] c;
    logic [7:0]  b;
    int          n;
    exp_q.delete();
    for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    n = (len < 60) ? 60 : len;
    for (int k = 0; k < n; k++) begin
      b = (k < len) ? pat(k) : 8'h00;
      exp_q.push_back(b);
      c = crc_step(c, b);
    end
    c = ~c;
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);
  endtask

  // Offer stream bytes first..first+count-1; S_LAST on index len-1.
  task automatic send_bytes(input int first, input int count, input int len);
    int n;
    for (int i = first; i < first + count; i++) begin
      s_if.data  = pat(i);
      s_if.valid = 1'b1;
      s_if.last  = (i == len - 1);
      n = 0;
      while (!s_if.ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!s_if.ready) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL handshake byte %0d: ready=%b, required 1 within 200 cycles", i, s_if.ready);
        break;
      end
      @(negedge clk);
    end
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    s_if.data  = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s idle timeout: busy=%b, required 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_if.valid = 1'b1;
    s_if.data  = 8'hA5;
    s_if.last  = 1'b0;
    repeat (3) @(negedge clk);
    n_compared++;
    if ({txd, txen, txer} !== 10'h000) begin
      n_mismatched++;
      $display("[TB] FAIL reset pins: got txd=%h txen=%b txer=%b, required 00/0/0", txd, txen, txer);
    end
    n_compared++;
    if ({s_if.ready, busy} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL reset ready/busy: got %b/%b, required 0/0", s_if.ready, busy);
    end
    n_compared++;
    if ({frame_cnt, abort_cnt} !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset counters: got %0d/%0d, required 0/0", frame_cnt, abort_cnt);
    end
    s_if.valid = 1'b0;
    s_if.data  = 8'h00;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_compared++;
    if ({busy, txen} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL idle after reset: got busy=%b txen=%b, required 0/0", busy, txen);
    end
  endtask

  task automatic test_frame_64();
    int base, t0, e0, bad;
    logic [31:0] res;
    base = cap_q.size();
    t0 = txen_cycles;
    e0 = txer_cycles;
    send_bytes(0, 64, 64);
    wait_idle("frame64");
    n_compared++;
    if (txen_cycles - t0 !== 76) begin
      n_mismatched++;
      $display("[TB] FAIL frame64 txen length: got %0d, required 76", txen_cycles - t0);
    end
    build_expected(64);
    bad = 0;
    res = 32'h0;
    if (cap_q.size() - base < 76) bad = 76;
    else begin
      for (int k = 0; k < 76; k++) if (cap_q[base + k] !== exp_q[k]) bad++;
      res = 32'hFFFFFFFF;
      for (int k = 8; k < 76; k++) res = crc_step(res, cap_q[base + k]);
    end
    n_compared++;
    if (bad !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL frame64 wire bytes: got %0d wrong, required 0", bad);
    end
    n_compared++;
    if (res !== 32'hDEBB20E3) begin
      n_mismatched++;
      $display("[TB] FAIL frame64 residue: got %h, required debb20e3", res);
    end
    n_compared++;
    if (frame_cnt !== 16'd1 || txer_cycles - e0 !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL frame64 counters: frame_cnt=%0d txer=%0d, required 1/0", frame_cnt, txer_cycles - e0);
    end
  endtask

  task automatic test_pad_14();
    int base, t0, bad, nz;
    base = cap_q.size();
    t0 = txen_cycles;
    send_bytes(0, 14, 14);
    wait_idle("pad14");
    n_compared++;
    if (txen_cycles - t0 !== 72) begin
      n_mismatched++;
      $display("[TB] FAIL pad14 txen length: got %0d, required 72", txen_cycles - t0);
    end
    build_expected(14);
    bad = 0;
    nz = 0;
    if (cap_q.size() - base < 72) begin
      bad = 72;
      nz = 46;
    end else begin
      for (int k = 0; k < 72; k++) if (cap_q[base + k] !== exp_q[k]) bad++;
      for (int k = 22; k < 68; k++) if (cap_q[base + k] !== 8'h00) nz++;
    end
    n_compared++;
    if (nz !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL pad14 pad bytes: got %0d nonzero, required 0", nz);
    end
    n_compared++;
    if (bad !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL pad14 wire bytes and FCS: got %0d wrong, required 0", bad);
    end
    n_compared++;
    if (frame_cnt !== 16'd2) begin
      n_mismatched++;
      $display("[TB] FAIL pad14 frame_cnt: got %0d, required 2", frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int base, t0, r0, f0, bad, gap;
    base = cap_q.size();
    t0 = txen_cycles;
    r0 = rise_q.size();
    f0 = fall_q.size();
    send_bytes(0, 60, 60);
    send_bytes(0, 64, 64);
    wait_idle("b2b");
    gap = -1;
    if (rise_q.size() - r0 >= 2 && fall_q.size() - f0 >= 1) gap = rise_q[r0 + 1] - fall_q[f0];
    n_compared++;
    if (gap !== 12) begin
      n_mismatched++;
      $display("[TB] FAIL b2b gap: got %0d idle cycles, required 12", gap);
    end
    n_compared++;
    if (txen_cycles - t0 !== 148) begin
      n_mismatched++;
      $display("[TB] FAIL b2b txen total: got %0d, required 148", txen_cycles - t0);
    end
    bad = 0;
    if (cap_q.size() - base < 148) bad = 148;
    else begin
      build_expected(60);
      for (int k = 0; k < 72; k++) if (cap_q[base + k] !== exp_q[k]) bad++;
      build_expected(64);
      for (int k = 0; k < 76; k++) if (cap_q[base + 72 + k] !== exp_q[k]) bad++;
    end
    n_compared++;
    if (bad !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b wire bytes: got %0d wrong, required 0", bad);
    end
    n_compared++;
    if (frame_cnt !== 16'd4) begin
      n_mismatched++;
      $display("[TB] FAIL b2b frame_cnt: got %0d, required 4", frame_cnt);
    end
  endtask

  task automatic test_underrun();
    int base, t0, e0, bad;
    base = cap_q.size();
    t0 = txen_cycles;
    e0 = txer_cycles;
    send_bytes(0, 20, 64);
    repeat (3) @(negedge clk);
    send_bytes(20, 44, 64);
    wait_idle("underrun");
    n_compared++;
    if (txen_cycles - t0 !== 29) begin
      n_mismatched++;
      $display("[TB] FAIL underrun txen length: got %0d, required 29", txen_cycles - t0);
    end
    n_compared++;
    if (txer_cycles - e0 !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL underrun txer cycles: got %0d, required 1", txer_cycles - e0);
    end
    build_expected(64);
    bad = 0;
    if (cap_q.size() - base < 29) bad = 29;
    else begin
      for (int k = 0; k < 28; k++) if (cap_q[base + k] !== exp_q[k]) bad++;
      if (cap_q[base + 28] !== 8'h00) bad++;
    end
    n_compared++;
    if (bad !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL underrun wire bytes: got %0d wrong, required 0", bad);
    end
    n_compared++;
    if (abort_cnt !== 16'd1 || frame_cnt !== 16'd4) begin
      n_mismatched++;
      $display("[TB] FAIL underrun counters: abort=%0d frame=%0d, required 1/4", abort_cnt, frame_cnt);
    end
  endtask

  task automatic test_oversize();
    int base, t0, e0, bad;
    logic [7:0] last_wire;
    base = cap_q.size();
    t0 = txen_cycles;
    e0 = txer_cycles;
    send_bytes(0, 1516, 1516);
    wait_idle("oversize");
    n_compared++;
    if (txen_cycles - t0 !== 1523 || txer_cycles - e0 !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL oversize txen/txer: got %0d/%0d, required 1523/1", txen_cycles - t0, txer_cycles - e0);
    end
    build_expected(1516);
    bad = 0;
    last_wire = 8'hFF;
    if (cap_q.size() - base < 1523) bad = 1523;
    else begin
      for (int k = 0; k < 1522; k++) if (cap_q[base + k] !== exp_q[k]) bad++;
      last_wire = cap_q[base + 1522];
    end
    n_compared++;
    if (bad !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL oversize wire bytes: got %0d wrong, required 0", bad);
    end
    n_compared++;
    if (last_wire !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL oversize byte 1515 suppressed: got %h on wire, required 00", last_wire);
    end
    n_compared++;
    if (abort_cnt !== 16'd2 || frame_cnt !== 16'd4) begin
      n_mismatched++;
      $display("[TB] FAIL oversize counters: abort=%0d frame=%0d, required 2/4", abort_cnt, frame_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base, t0, bad;
    logic [31:0] res;
    send_bytes(0, 30, 64);
    n_compared++;
    if (txen !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL midreset txen before reset: got %b, required 1", txen);
    end
    rst = 1'b1;
    @(negedge clk);
    n_compared++;
    if ({txen, txer, busy} !== 3'b000) begin
      n_mismatched++;
      $display("[TB] FAIL midreset pins: got txen=%b txer=%b busy=%b, required 0/0/0", txen, txer, busy);
    end
    n_compared++;
    if ({frame_cnt, abort_cnt} !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset counters: got %0d/%0d, required 0/0", frame_cnt, abort_cnt);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    base = cap_q.size();
    t0 = txen_cycles;
    send_bytes(0, 64, 64);
    wait_idle("midreset");
    build_expected(64);
    bad = 0;
    res = 32'h0;
    if (cap_q.size() - base < 76 || txen_cycles - t0 !== 76) bad = 76;
    else begin
      for (int k = 0; k < 76; k++) if (cap_q[base + k] !== exp_q[k]) bad++;
      res = 32'hFFFFFFFF;
      for (int k = 8; k < 76; k++) res = crc_step(res, cap_q[base + k]);
    end
    n_compared++;
    if (bad !== 0 || res !== 32'hDEBB20E3) begin
      n_mismatched++;
      $display("[TB] FAIL midreset next frame: got %0d wrong bytes residue %h, required 0 / debb20e3", bad, res);
    end
    n_compared++;
    if (frame_cnt !== 16'd1) begin
      n_mismatched++;
      $display("[TB] FAIL midreset frame_cnt: got %0d, required 1", frame_cnt);
    end
  endtask

  initial begin
    rst        = 1'b1;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    s_if.data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_frame_64();
    test_pad_14();
    test_back_to_back();
    test_underrun();
    test_oversize();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
